data_mem_stage: RTL and testbench
=================================

Name: data_mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline: consumes the EX/MEM pipeline register, performs data-memory load/store and branch resolution, and drives the MEM/WB pipeline register that feeds write-back.
- Holds the byte-addressed, big-endian data RAM (`ram`), preloadable hierarchically by benches.
- Supports unaligned word and halfword access with signed and unsigned halfword loads.

Parameters:
- DEPTH, 4096, data RAM size in bytes; must be a power of two.
- ADDR_W, 12, log2(DEPTH); low bits of the ALU address used for indexing.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold MEM/WB register and suppress stores this cycle
- mem_reg_write  in  1  EX/MEM RegWrite
- mem_mem_write  in  1  EX/MEM MemWrite (sw)
- mem_mem_read  in  1  EX/MEM MemRead
- mem_mem_to_reg  in  1  EX/MEM MemToReg
- mem_branch  in  1  EX/MEM Branch
- mem_zero  in  1  EX/MEM ALU zero flag
- mem_address  in  32  ALU result / byte address
- mem_write_data  in  32  store data (rt)
- mem_write_back_destination  in  5  destination register
- mem_load_mode  in  2  load width/sign select
- pc_src  out  1  branch taken to IF stage
- wb_reg_write  out  1  MEM/WB RegWrite
- wb_mem_to_reg  out  1  MEM/WB MemToReg
- wb_write_back_destination  out  5  MEM/WB destination
- wb_read_data  out  32  MEM/WB loaded data
- wb_address  out  32  MEM/WB ALU result

Behaviour:
- Single clock domain `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: all wb_* outputs are 0. RAM contents are not affected by reset. pc_src is combinational and not registered.
- pc_src = mem_branch & mem_zero, combinational in the same cycle.
- Byte index i = mem_address[ADDR_W-1:0]. Access to byte i+k uses (i+k) mod DEPTH, so accesses wrap at the end of RAM. Upper address bits are ignored.
- Big-endian: the word at i is {ram[i], ram[i+1], ram[i+2], ram[i+3]}. The halfword at i is {ram[i], ram[i+1]}.
- Store: on rising clk, if mem_mem_write=1 and stall=0, write all 4 bytes of mem_write_data big-endian at i. Only word stores are supported.
- Load read path is combinational from current RAM contents. It is registered into wb_read_data at rising clk. Total latency is 1 cycle from EX/MEM to MEM/WB.
- mem_load_mode encoding:
  - 00: word.
  - 01: halfword, sign-extended.
  - 10: halfword, zero-extended.
  - 11: byte at i, zero-extended.
- If mem_mem_read=0, the value captured into wb_read_data is 0.
- Rising clk with stall=0: all wb_* outputs take their EX/MEM counterparts; wb_address takes mem_address.
- Rising clk with stall=1: all wb_* outputs hold their values and no RAM write occurs. pc_src is still computed.
- Simultaneous read and write cannot come from one instruction. If both flags are asserted, the load captures the pre-write data (read-before-write) and the store then commits.
- Reset asserted mid-operation clears the MEM/WB register immediately (asynchronous). A store on an edge coincident with rst_n low is not performed.
- A nop (all control bits 0) passes through as a bubble. wb_reg_write=0 guarantees no register write.

Decomposition:
- Shared package mips_pkg holds LOAD_WORD=2'b00, LOAD_HALF=2'b01, LOAD_HALF_U=2'b10, LOAD_BYTE_U=2'b11, plus the data-width and register-index-width constants.
- One sub-module, data_ram: byte array `ram` with a synchronous big-endian word write port and a combinational 4-byte read port with modulo wrap.
- The load-extend mux and the MEM/WB register stay in data_mem_stage.

Test Plan:
- Store then load: sw 0x00000FFF at addr 0, then lw addr 0 → wb_read_data=0x00000FFF; ram[0..3]=00,00,0F,FF.
- Unaligned halfword, same RAM: lh addr 3 → wb_read_data=0xFFFFFF00; lhu addr 3 → 0x0000FF00; byte mode addr 2 → 0x0000000F.
- Wrap-around: sw 0x11223344 at addr DEPTH-2 → ram[DEPTH-2]=11, ram[DEPTH-1]=22, ram[0]=33, ram[1]=44; lw at DEPTH-2 returns 0x11223344.
- Branch: mem_branch=1 with mem_zero=1 → pc_src=1 in the same cycle; mem_zero=0 → pc_src=0. Pass-through check: mem_address=12, dest=5'h10, reg_write=1 → next edge wb_address=12, wb_write_back_destination=5'h10, wb_read_data=0.
- Stall: load in flight with stall=1 → wb_* hold their previous values; a sw asserted during stall leaves RAM unchanged; after stall deasserts, the next edge captures normally.
- Reset: drive a valid load, then pull rst_n low between edges → wb_* are 0 immediately; RAM keeps the prior 0x00000FFF at addr 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: data/register widths and the
// load-mode encoding that selects width and sign of a MEM-stage load.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] LOAD_WORD   = 2'b00;
  localparam logic [1:0] LOAD_HALF   = 2'b01;
  localparam logic [1:0] LOAD_HALF_U = 2'b10;
  localparam logic [1:0] LOAD_BYTE_U = 2'b11;
endpackage

// File: rtl/data_ram.sv
// Byte-addressed big-endian data RAM: synchronous word write and combinational
// 4-byte read. Byte offsets wrap modulo DEPTH so a word can straddle the end.
module data_ram
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [7:0] ram [DEPTH];

  logic [ADDR_W-1:0] a1, a2, a3;

  // ADDR_W-bit adds give the modulo-DEPTH wrap for free.
  always_comb begin
    a1 = addr_i + ADDR_W'(1);
    a2 = addr_i + ADDR_W'(2);
    a3 = addr_i + ADDR_W'(3);
  end

  assign rdata_o = {ram[addr_i], ram[a1], ram[a2], ram[a3]};

  // No reset on contents; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (we_i && rst_n) begin
      ram[addr_i] <= wdata_i[31:24];
      ram[a1]     <= wdata_i[23:16];
      ram[a2]     <= wdata_i[15:8];
      ram[a3]     <= wdata_i[7:0];
    end
  end
endmodule

// File: rtl/data_mem_stage.sv
// MEM stage: data-RAM access, load width/sign extension, branch resolution,
// and the MEM/WB pipeline register (held while stall is high).
module data_mem_stage
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              mem_reg_write,
  input  logic              mem_mem_write,
  input  logic              mem_mem_read,
  input  logic              mem_mem_to_reg,
  input  logic              mem_branch,
  input  logic              mem_zero,
  input  logic [DATA_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic [REG_W-1:0]  mem_write_back_destination,
  input  logic [1:0]        mem_load_mode,
  output logic              pc_src,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_W-1:0]  wb_write_back_destination,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_address
);
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] load_d;

  logic              reg_write_q, mem_to_reg_q;
  logic [REG_W-1:0]  dest_q;
  logic [DATA_W-1:0] read_data_q, address_q;

  assign pc_src = mem_branch & mem_zero;

  data_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_mem_write & ~stall),
    .addr_i  (mem_address[ADDR_W-1:0]),
    .wdata_i (mem_write_data),
    .rdata_o (ram_rdata)
  );

  // The read word starts at byte i, so halfword/byte live in the top bits.
  always_comb begin
    load_d = '0;
    if (mem_mem_read) begin
      case (mem_load_mode)
        LOAD_WORD:   load_d = ram_rdata;
        LOAD_HALF:   load_d = {{16{ram_rdata[31]}}, ram_rdata[31:16]};
        LOAD_HALF_U: load_d = {16'h0000, ram_rdata[31:16]};
        LOAD_BYTE_U: load_d = {24'h000000, ram_rdata[31:24]};
        default:     load_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      dest_q       <= '0;
      read_data_q  <= '0;
      address_q    <= '0;
    end else if (!stall) begin
      reg_write_q  <= mem_reg_write;
      mem_to_reg_q <= mem_mem_to_reg;
      dest_q       <= mem_write_back_destination;
      read_data_q  <= load_d;
      address_q    <= mem_address;
    end
  end

  assign wb_reg_write              = reg_write_q;
  assign wb_mem_to_reg             = mem_to_reg_q;
  assign wb_write_back_destination = dest_q;
  assign wb_read_data              = read_data_q;
  assign wb_address                = address_q;
endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: stores/loads, unaligned and wrapping
// accesses, branch resolution, stall hold and asynchronous reset.
module tb_data_mem_stage;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_to_reg;
  logic        mem_branch, mem_zero;
  logic [31:0] mem_address, mem_write_data;
  logic [4:0]  mem_write_back_destination;
  logic [1:0]  mem_load_mode;
  logic        pc_src, wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_write_back_destination;
  logic [31:0] wb_read_data, wb_address;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_stage dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .stall                      (stall),
    .mem_reg_write              (mem_reg_write),
    .mem_mem_write              (mem_mem_write),
    .mem_mem_read               (mem_mem_read),
    .mem_mem_to_reg             (mem_mem_to_reg),
    .mem_branch                 (mem_branch),
    .mem_zero                   (mem_zero),
    .mem_address                (mem_address),
    .mem_write_data             (mem_write_data),
    .mem_write_back_destination (mem_write_back_destination),
    .mem_load_mode              (mem_load_mode),
    .pc_src                     (pc_src),
    .wb_reg_write               (wb_reg_write),
    .wb_mem_to_reg              (wb_mem_to_reg),
    .wb_write_back_destination  (wb_write_back_destination),
    .wb_read_data               (wb_read_data),
    .wb_address                 (wb_address)
  );

  // Driver: apply one EX/MEM instruction at the falling edge, then sample
  // 1 time unit after the following rising edge.
  task automatic do_op(input logic wr, input logic rd, input logic [1:0] mode,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] dest, input logic rw, input logic m2r,
                       input logic stl);
    @(negedge clk);
    mem_mem_write = wr;
    mem_mem_read = rd;
    mem_load_mode = mode;
    mem_address = addr;
    mem_write_data = wdata;
    mem_write_back_destination = dest;
    mem_reg_write = rw;
    mem_mem_to_reg = m2r;
    mem_branch = 1'b0;
    mem_zero = 1'b0;
    stall = stl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    mem_reg_write = 1'b0; mem_mem_write = 1'b0; mem_mem_read = 1'b0;
    mem_mem_to_reg = 1'b0; mem_branch = 1'b0; mem_zero = 1'b0;
    mem_address = '0; mem_write_data = '0;
    mem_write_back_destination = '0; mem_load_mode = 2'b00;
    #3;
    n_cmp++;
    if ({wb_reg_write, wb_mem_to_reg, wb_write_back_destination, wb_read_data, wb_address} !== 71'd0) begin
      n_err++;
      $display("FAIL reset_state: got rw=%b m2r=%b dest=%h rd=%h addr=%h expected all 0",
               wb_reg_write, wb_mem_to_reg, wb_write_back_destination, wb_read_data, wb_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    do_op(1, 0, 2'b00, 32'd4, 32'h0, 5'd0, 0, 0, 0);
    do_op(1, 0, 2'b00, 32'd0, 32'h00000FFF, 5'd0, 0, 0, 0);
    n_cmp++;
    if ({dut.u_ram.ram[0], dut.u_ram.ram[1], dut.u_ram.ram[2], dut.u_ram.ram[3]} !== 32'h00000FFF) begin
      n_err++;
      $display("FAIL sw_bytes: got %h %h %h %h expected 00 00 0f ff",
               dut.u_ram.ram[0], dut.u_ram.ram[1], dut.u_ram.ram[2], dut.u_ram.ram[3]);
    end
    do_op(0, 1, 2'b00, 32'd0, 32'h0, 5'd2, 1, 1, 0);
    n_cmp++;
    if (wb_read_data !== 32'h00000FFF) begin
      n_err++;
      $display("FAIL lw_addr0: got %h expected 00000fff", wb_read_data);
    end
  endtask

  task automatic test_unaligned();
    do_op(0, 1, 2'b01, 32'd3, 32'h0, 5'd2, 1, 1, 0);
    n_cmp++;
    if (wb_read_data !== 32'hFFFFFF00) begin
      n_err++;
      $display("FAIL lh_addr3: got %h expected ffffff00", wb_read_data);
    end
    do_op(0, 1, 2'b10, 32'd3, 32'h0, 5'd2, 1, 1, 0);
    n_cmp++;
    if (wb_read_data !== 32'h0000FF00) begin
      n_err++;
      $display("FAIL lhu_addr3: got %h expected 0000ff00", wb_read_data);
    end
    do_op(0, 1, 2'b11, 32'd2, 32'h0, 5'd2, 1, 1, 0);
    n_cmp++;
    if (wb_read_data !== 32'h0000000F) begin
      n_err++;
      $display("FAIL lbu_addr2: got %h expected 0000000f", wb_read_data);
    end
    do_op(0, 1, 2'b11, 32'd3, 32'h0, 5'd2, 1, 1, 0);
    n_cmp++;
    if (wb_read_data !== 32'h000000FF) begin
      n_err++;
      $display("FAIL lbu_addr3: got %h expected 000000ff", wb_read_data);
    end
  endtask

  task automatic test_branch_passthrough();
    @(negedge clk);
    mem_branch = 1'b1;
    mem_zero = 1'b1;
    #1;
    n_cmp++;
    if (pc_src !== 1'b1) begin
      n_err++;
      $display("FAIL pc_src_taken: got %b expected 1", pc_src);
    end
    mem_zero = 1'b0;
    #1;
    n_cmp++;
    if (pc_src !== 1'b0) begin
      n_err++;
      $display("FAIL pc_src_not_taken: got %b expected 0", pc_src);
    end
    do_op(0, 0, 2'b00, 32'd12, 32'h0, 5'h10, 1, 0, 0);
    n_cmp++;
    if ({wb_address, wb_write_back_destination, wb_read_data, wb_reg_write, wb_mem_to_reg}
        !== {32'd12, 5'h10, 32'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL passthrough: got addr=%h dest=%h rd=%h rw=%b m2r=%b expected addr=0000000c dest=10 rd=0 rw=1 m2r=0",
               wb_address, wb_write_back_destination, wb_read_data, wb_reg_write, wb_mem_to_reg);
    end
  endtask

  task automatic test_stall();
    do_op(0, 1, 2'b00, 32'd0, 32'h0, 5'd3, 1, 1, 0);
    n_cmp++;
    if ({wb_read_data, wb_address, wb_write_back_destination} !== {32'h00000FFF, 32'd0, 5'd3}) begin
      n_err++;
      $display("FAIL pre_stall_load: got rd=%h addr=%h dest=%h expected 00000fff 00000000 03",
               wb_read_data, wb_address, wb_write_back_destination);
    end
    do_op(0, 1, 2'b11, 32'd2, 32'h0, 5'd7, 0, 0, 1);
    n_cmp++;
    if ({wb_read_data, wb_address, wb_write_back_destination, wb_reg_write, wb_mem_to_reg}
        !== {32'h00000FFF, 32'd0, 5'd3, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL stall_hold: got rd=%h addr=%h dest=%h rw=%b m2r=%b expected 00000fff 00000000 03 1 1",
               wb_read_data, wb_address, wb_write_back_destination, wb_reg_write, wb_mem_to_reg);
    end
    do_op(1, 0, 2'b00, 32'd4, 32'hDEADBEEF, 5'd0, 0, 0, 1);
    n_cmp++;
    if ({dut.u_ram.ram[4], dut.u_ram.ram[5], dut.u_ram.ram[6], dut.u_ram.ram[7]} !== 32'h0) begin
      n_err++;
      $display("FAIL stall_store: got %h %h %h %h expected 00 00 00 00",
               dut.u_ram.ram[4], dut.u_ram.ram[5], dut.u_ram.ram[6], dut.u_ram.ram[7]);
    end
    do_op(0, 1, 2'b00, 32'd3, 32'h0, 5'd9, 1, 1, 0);
    n_cmp++;
    if ({wb_read_data, wb_address, wb_write_back_destination} !== {32'hFF000000, 32'd3, 5'd9}) begin
      n_err++;
      $display("FAIL post_stall: got rd=%h addr=%h dest=%h expected ff000000 00000003 09",
               wb_read_data, wb_address, wb_write_back_destination);
    end
  endtask

  task automatic test_read_before_write();
    do_op(1, 1, 2'b00, 32'd4, 32'hA5A5A5A5, 5'd1, 1, 1, 0);
    n_cmp++;
    if (wb_read_data !== 32'h0) begin
      n_err++;
      $display("FAIL rbw_load: got %h expected 00000000", wb_read_data);
    end
    n_cmp++;
    if ({dut.u_ram.ram[4], dut.u_ram.ram[7]} !== 16'hA5A5) begin
      n_err++;
      $display("FAIL rbw_store: got %h %h expected a5 a5", dut.u_ram.ram[4], dut.u_ram.ram[7]);
    end
  endtask

  task automatic test_async_reset();
    do_op(0, 1, 2'b00, 32'd0, 32'h0, 5'd4, 1, 1, 0);
    @(negedge clk);
    mem_mem_write = 1'b1;
    mem_mem_read = 1'b0;
    mem_address = 32'd0;
    mem_write_data = 32'h12345678;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wb_reg_write, wb_mem_to_reg, wb_write_back_destination, wb_read_data, wb_address} !== 71'd0) begin
      n_err++;
      $display("FAIL async_reset: got rw=%b m2r=%b dest=%h rd=%h addr=%h expected all 0",
               wb_reg_write, wb_mem_to_reg, wb_write_back_destination, wb_read_data, wb_address);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({dut.u_ram.ram[0], dut.u_ram.ram[1], dut.u_ram.ram[2], dut.u_ram.ram[3]} !== 32'h00000FFF) begin
      n_err++;
      $display("FAIL reset_ram_keep: got %h %h %h %h expected 00 00 0f ff",
               dut.u_ram.ram[0], dut.u_ram.ram[1], dut.u_ram.ram[2], dut.u_ram.ram[3]);
    end
    @(negedge clk);
    mem_mem_write = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    do_op(1, 0, 2'b00, 32'(DEPTH - 2), 32'h11223344, 5'd0, 0, 0, 0);
    n_cmp++;
    if ({dut.u_ram.ram[DEPTH-2], dut.u_ram.ram[DEPTH-1], dut.u_ram.ram[0], dut.u_ram.ram[1]} !== 32'h11223344) begin
      n_err++;
      $display("FAIL wrap_bytes: got %h %h %h %h expected 11 22 33 44",
               dut.u_ram.ram[DEPTH-2], dut.u_ram.ram[DEPTH-1], dut.u_ram.ram[0], dut.u_ram.ram[1]);
    end
    do_op(0, 1, 2'b00, 32'(DEPTH - 2), 32'h0, 5'd6, 1, 1, 0);
    n_cmp++;
    if (wb_read_data !== 32'h11223344) begin
      n_err++;
      $display("FAIL wrap_lw: got %h expected 11223344", wb_read_data);
    end
    // Upper address bits are ignored for indexing but still reach wb_address.
    do_op(0, 1, 2'b10, 32'h8000_0FFF, 32'h0, 5'd6, 1, 1, 0);
    n_cmp++;
    if ({wb_read_data, wb_address} !== {32'h00002233, 32'h8000_0FFF}) begin
      n_err++;
      $display("FAIL wrap_lhu_hi_addr: got rd=%h addr=%h expected 00002233 80000fff",
               wb_read_data, wb_address);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_unaligned();
    test_branch_passthrough();
    test_stall();
    test_read_before_write();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
